// File: rtl/ld_cell_a2d.sv
// ld_cell_a2d: round-robin SPI front end for the 8-channel 12-bit ADC.
// Each nxt converts the next of left, right, steer pot, battery channels.
module ld_cell_a2d #(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [2:0] {
        IDLE,
        XFER1,
        GAP,
        XFER2,
        UPDATE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [3:0]  r_cnt;
    logic [4:0]  r_bits;
    logic        r_gap;
    logic [15:0] r_shreg;
    logic        r_ss_n;
    logic        r_cmplt;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_steer;
    logic [11:0] r_batt;

    logic [2:0]  w_ch;
    logic [15:0] w_cmd;
    logic        w_done;
    logic        w_rise;

    always_comb begin
        w_ch = LFT_CH;
        unique case (r_ptr)
            2'd0: w_ch = LFT_CH;
            2'd1: w_ch = RGHT_CH;
            2'd2: w_ch = STEER_CH;
            2'd3: w_ch = BATT_CH;
        endcase
    end

    assign w_cmd  = {2'b00, w_ch, 11'h000};
    // Frame ends once all 16 bits are in and the divider has run out,
    // so the trailing SCLK fall never happens.
    assign w_done = (r_cnt == 4'hF) && (r_bits == 5'd16);
    assign w_rise = (r_cnt == 4'h7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'hF;
            r_bits  <= 5'd0;
            r_gap   <= 1'b0;
            r_shreg <= 16'h0000;
            r_ss_n  <= 1'b1;
            r_cmplt <= 1'b0;
            r_lft   <= 12'h000;
            r_rght  <= 12'h000;
            r_steer <= 12'h000;
            r_batt  <= 12'h000;
        end else begin
            r_cmplt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (nxt) begin
                        r_state <= XFER1;
                        r_ss_n  <= 1'b0;
                        r_cnt   <= 4'hB;
                        r_bits  <= 5'd0;
                        r_shreg <= w_cmd;
                    end
                end
                XFER1, XFER2: begin
                    if (w_done) begin
                        r_ss_n <= 1'b1;
                        r_gap  <= 1'b0;
                        if (r_state == XFER1) begin
                            r_state <= GAP;
                        end else begin
                            r_state <= UPDATE;
                            r_cmplt <= 1'b1;
                            case (r_ptr)
                                2'd0: r_lft   <= r_shreg[11:0];
                                2'd1: r_rght  <= r_shreg[11:0];
                                2'd2: r_steer <= r_shreg[11:0];
                                default: r_batt <= r_shreg[11:0];
                            endcase
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_rise) begin
                            r_shreg <= {r_shreg[14:0], MISO};
                            r_bits  <= r_bits + 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (r_gap) begin
                        r_state <= XFER2;
                        r_ss_n  <= 1'b0;
                        r_cnt   <= 4'hB;
                        r_bits  <= 5'd0;
                        r_shreg <= w_cmd;
                    end else begin
                        r_gap <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_ptr   <= r_ptr + 2'd1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lft_ld    = r_lft;
    assign rght_ld   = r_rght;
    assign steer_pot = r_steer;
    assign batt      = r_batt;
    assign cnv_cmplt = r_cmplt;
    assign SS_n      = r_ss_n;
    assign SCLK      = r_ss_n | r_cnt[3];
    assign MOSI      = r_shreg[15];

endmodule

// File: tb/tb_ld_cell_a2d.sv
// tb_ld_cell_a2d: directed bench with an ADC slave model and a
// cycle-level conversion model for ld_cell_a2d.
module tb_ld_cell_a2d;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt, SS_n, SCLK, MOSI;
    logic        MISO;

    ld_cell_a2d dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt),
        .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt),
        .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO)
    );

    initial forever #10 clk = ~clk;

    int nvec = 0;
    int nfail = 0;
    int ncmplt = 0;

    function automatic logic [2:0] chan(input int p);
        case (p)
            1: return 3'd4;
            2: return 3'd5;
            3: return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // ADC slave: answers each frame with the channel addressed by the
    // previous complete frame, upper nibble forced to F.
    logic [11:0] adc_val [8] = '{default: 12'h000};
    logic [15:0] adc_tx = 16'h0000;
    logic [2:0]  last_ch = 3'd0;
    bit          in_frame = 1'b0;
    logic [15:0] rx_cmd = 16'h0000;
    int          rx_n = 0;

    assign MISO = adc_tx[15];

    initial forever begin
        @(negedge SS_n or posedge SCLK or posedge SS_n);
        if (SS_n !== 1'b0) begin
            if (in_frame && rx_n == 16) last_ch = rx_cmd[13:11];
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            adc_tx = {4'hF, adc_val[last_ch]};
        end else begin
            adc_tx = {adc_tx[14:0], 1'b0};
        end
    end

    // Conversion model: pure timing arithmetic from the accept edge.
    int          cyc = 0;
    int          start = 0;
    bit          act = 1'b0;
    int          m_ptr = 0;
    logic [11:0] m_res [4] = '{default: 12'h000};
    logic        m_ss = 1'b1;
    logic        m_sclk = 1'b1;
    logic        m_cmplt = 1'b0;

    initial forever begin
        int k;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; act = 1'b0; m_ptr = 0;
            m_res = '{default: 12'h000};
            m_ss = 1'b1; m_sclk = 1'b1; m_cmplt = 1'b0;
        end else begin
            cyc++;
            if (!act && nxt) begin
                act = 1'b1;
                start = cyc;
            end
            k = cyc - start;
            m_cmplt = act && (k == 524);
            if (m_cmplt) m_res[m_ptr] = adc_val[chan(m_ptr)];
            if (act && k == 525) begin
                act = 1'b0;
                m_ptr = (m_ptr + 1) % 4;
            end
            if (act && k < 261) begin
                m_ss = 1'b0;
                m_sclk = ((11 + k) % 16) >= 8;
            end else if (act && k >= 263 && k < 524) begin
                m_ss = 1'b0;
                m_sclk = ((11 + k - 263) % 16) >= 8;
            end else begin
                m_ss = 1'b1;
                m_sclk = 1'b1;
            end
        end
    end

    // MOSI frames captured mid-bit on SCLK fall.
    logic [15:0] frm_act [64];
    logic [15:0] frm_exp [64];
    int          nfrm = 0;
    int          chk_f = 0;

    initial forever begin
        @(negedge SCLK or negedge SS_n);
        if (SCLK === 1'b1) begin
            rx_n = 0;
        end else if (SS_n === 1'b0) begin
            rx_cmd = {rx_cmd[14:0], MOSI};
            rx_n++;
            if (rx_n == 16 && nfrm < 64) begin
                frm_act[nfrm] = rx_cmd;
                frm_exp[nfrm] = {2'b00, chan(m_ptr), 11'h000};
                nfrm++;
            end
        end
    end

    int run_lo = 0, run_hi = 0, last_low = 0, last_high = 0;

    initial forever begin
        @(posedge clk);
        if (SS_n === 1'b0) begin
            if (run_hi != 0) begin last_high = run_hi; run_hi = 0; end
            run_lo++;
        end else begin
            if (run_lo != 0) begin last_low = run_lo; run_lo = 0; end
            run_hi++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("cycle",
                {SS_n, SCLK, cnv_cmplt, lft_ld, rght_ld, steer_pot, batt},
                {m_ss, m_sclk, m_cmplt, m_res[0], m_res[1], m_res[2], m_res[3]});
            if (cnv_cmplt === 1'b1) ncmplt++;
            while (chk_f < nfrm) begin
                chk("frame", frm_act[chk_f], frm_exp[chk_f]);
                chk_f++;
            end
        end
    endtask

    task automatic convert();
        nxt = 1'b1;
        step(1);
        nxt = 1'b0;
        step(530);
    endtask

    logic [15:0] seq_cmd [4] = '{16'h2000, 16'h2800, 16'h3000, 16'h0000};
    logic [11:0] seq_val [4] = '{12'h3C7, 12'h81E, 12'hBAD, 12'h064};

    initial begin
        int f0;
        logic [11:0] got;

        step(3);
        rst_n = 1'b1;
        chk("rst_res", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        chk("rst_ss", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_cmplt", cnv_cmplt, 0);
        chk("rst_mosi", MOSI, 0);

        ncmplt = 0;
        step(1000);
        chk("idle_frames", nfrm, 0);
        chk("idle_cmplt", ncmplt, 0);

        adc_val[0] = 12'hA5C;
        ncmplt = 0;
        convert();
        chk("single_lft", lft_ld, 12'hA5C);
        chk("single_rest", {rght_ld, steer_pot, batt}, 36'h0);
        chk("single_x1", frm_act[0], 16'h0000);
        chk("single_x2", frm_act[1], 16'h0000);
        chk("single_cmplt", ncmplt, 1);
        chk("ss_low", last_low, 261);
        chk("ss_gap", last_high, 2);

        adc_val[4] = 12'h3C7;
        adc_val[5] = 12'h81E;
        adc_val[6] = 12'hBAD;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) adc_val[0] = 12'h064;
            f0 = nfrm;
            convert();
            chk("seq_x1", frm_act[f0], seq_cmd[i]);
            chk("seq_x2", frm_act[f0 + 1], seq_cmd[i]);
            case (i)
                0: got = rght_ld;
                1: got = steer_pot;
                2: got = batt;
                default: got = lft_ld;
            endcase
            chk("seq_val", got, seq_val[i]);
        end
        chk("seq_all", {lft_ld, rght_ld, steer_pot, batt},
            48'h064_3C7_81E_BAD);

        adc_val[4] = 12'h111;
        adc_val[5] = 12'h222;
        adc_val[6] = 12'h333;
        ncmplt = 0;
        nxt = 1'b1;
        step(1578);
        nxt = 1'b0;
        step(600);
        chk("hold_cmplt", ncmplt, 3);
        chk("hold_all", {lft_ld, rght_ld, steer_pot, batt},
            48'h064_111_222_333);

        adc_val[0] = 12'h9F0;
        ncmplt = 0;
        for (int k = 0; k < 1100; k++) begin
            nxt = (k == 0 || k == 100 || k == 262 || k == 400 ||
                   k == 524 || k == 525);
            step(1);
        end
        nxt = 1'b0;
        chk("busy_cmplt", ncmplt, 1);
        chk("busy_lft", lft_ld, 12'h9F0);

        adc_val[4] = 12'hABC;
        nxt = 1'b1;
        step(1);
        nxt = 1'b0;
        step(400);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_ss", SS_n, 1);
        chk("arst_sclk", SCLK, 1);
        chk("arst_cmplt", cnv_cmplt, 0);
        chk("arst_res", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        step(2);
        rst_n = 1'b1;
        adc_val[0] = 12'h7E1;
        f0 = nfrm;
        convert();
        chk("arst_x1", frm_act[f0], 16'h0000);
        chk("arst_lft", lft_ld, 12'h7E1);
        chk("arst_rght", rght_ld, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
